// File: rtl/collatz_pkg.sv
// Shared types and constants for the collatz arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package collatz_pkg;

    typedef logic [15:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPLY
    } state_t;

    // Count returned when a sequence exceeds the iteration limit
    localparam count_t COUNT_ABORT = 16'hFFFF;

endpackage

// File: rtl/collatz_arbiter_if.sv
// Requester-side bundle of the collatz arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid held until req_ready; responses cannot be stalled.
// Ports: req_valid/req_n/req_ready (request handshake), rsp_valid/rsp_count
// (one-cycle result pulse), busy, owner (current or last granted index).
interface collatz_arbiter_if
    import collatz_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_BITS = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_n;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    count_t             rsp_count;
    logic               busy;
    logic [ID_BITS-1:0] owner;

    // Requesters
    modport master (
        output req_valid, req_n,
        input  req_ready, rsp_valid, rsp_count, busy, owner
    );

    // Arbiter
    modport slave (
        input  req_valid, req_n,
        output req_ready, rsp_valid, rsp_count, busy, owner
    );
endinterface

// File: rtl/collatz.sv
// Collatz iterator: loads cn on cgo, then steps one term per cycle until 1.
// Latency: dout shows cn the cycle after cgo, then the next term each cycle.
// Backpressure: none; the owner ignores dout until it needs it.
// Ports: clk, reset (sync, active high), cgo/cn (load), dout (current term).
module collatz (
    input  logic        clk,
    input  logic        reset,
    input  logic        cgo,
    input  logic [31:0] cn,
    output logic [31:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (cgo) begin
            dout <= cn;
        end else if (dout > 32'd1) begin
            // odd: 3n+1 built as 2n+n+1; even: halve
            dout <= dout[0] ? ({dout[30:0], 1'b0} + dout + 32'd1) : (dout >> 1);
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: req (request vector), ptr (scan start), found, idx, grant (one-hot).
module rr_pick #(
    parameter  int NREQ    = 4,
    localparam int ID_BITS = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]    req,
    input  logic [ID_BITS-1:0] ptr,
    output logic               found,
    output logic [ID_BITS-1:0] idx,
    output logic [NREQ-1:0]    grant
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = ID_BITS'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/collatz_arbiter.sv
// Shares one collatz iterator among NREQ requesters, round-robin.
// Latency: accept at T with sequence length L -> rsp at T+L+1 (n==0: T+1).
// Backpressure: one grant per IDLE; losers hold req_valid; rsp never stalls.
// Ports: clk, reset (sync, active high), bus (collatz_arbiter_if.slave).
module collatz_arbiter
    import collatz_pkg::*;
#(
    parameter int     NREQ     = 4,
    parameter int     ID_BITS  = 2,
    parameter count_t MAX_ITER = 16'hFFFE
) (
    input  logic               clk,
    input  logic               reset,
    collatz_arbiter_if.slave   bus
);

    state_t             state, state_n;
    count_t             cnt, cnt_n;
    count_t             rsp_count_q, rsp_count_n;
    logic [ID_BITS-1:0] ptr, ptr_n;
    logic [ID_BITS-1:0] owner_q, owner_n;

    logic               found;
    logic [ID_BITS-1:0] g_idx;
    logic [NREQ-1:0]    g_oh;
    logic [31:0]        sel_n;
    logic [31:0]        cn;
    logic [31:0]        c_dout;
    logic               cgo;
    logic               cdone;
    logic               accept;
    logic [NREQ-1:0]    ready_c;
    logic [NREQ-1:0]    rsp_c;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (g_idx),
        .grant (g_oh)
    );

    collatz u_collatz (
        .clk   (clk),
        .reset (reset),
        .cgo   (cgo),
        .cn    (cn),
        .dout  (c_dout)
    );

    assign cdone = (c_dout == 32'd1);

    // Start value of the winning requester
    always_comb begin
        sel_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_oh[i]) sel_n = sel_n | bus.req_n[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_count_q <= '0;
            ptr         <= '0;
            owner_q     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rsp_count_q <= rsp_count_n;
            ptr         <= ptr_n;
            owner_q     <= owner_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rsp_count_n = rsp_count_q;
        ptr_n       = ptr;
        owner_n     = owner_q;
        cgo         = 1'b0;
        cn          = '0;
        accept      = 1'b0;
        ready_c     = '0;
        rsp_c       = '0;
        // Nothing is accepted or returned while reset is held
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        accept  = 1'b1;
                        ready_c = g_oh;
                        owner_n = g_idx;
                        ptr_n   = (g_idx == ID_BITS'(NREQ - 1)) ? '0 : g_idx + ID_BITS'(1);
                        if (sel_n == 32'd0) begin
                            // n==0 has no sequence: answer without launching
                            rsp_count_n = '0;
                            state_n     = REPLY;
                        end else begin
                            cgo     = 1'b1;
                            cn      = sel_n;
                            cnt_n   = 16'd1;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cdone) begin
                        rsp_count_n = cnt;
                        state_n     = REPLY;
                    end else if (cnt == MAX_ITER) begin
                        rsp_count_n = COUNT_ABORT;
                        state_n     = REPLY;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                REPLY: begin
                    for (int i = 0; i < NREQ; i++) begin
                        rsp_c[i] = (owner_q == ID_BITS'(i));
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_c;
    assign bus.rsp_count = rsp_count_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state != IDLE) || accept;

endmodule

// File: tb/tb_collatz_arbiter.sv
// Bench for collatz_arbiter: scoreboard of expected responses per DUT.
// Latency: n/a.
// Backpressure: n/a.
module tb_collatz_arbiter;
    import collatz_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    collatz_arbiter_if #(.NREQ(4), .ID_BITS(2)) bus1 ();
    collatz_arbiter_if #(.NREQ(4), .ID_BITS(2)) bus2 ();

    collatz_arbiter #(.NREQ(4), .ID_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    collatz_arbiter #(.NREQ(4), .ID_BITS(2), .MAX_ITER(16'd10)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        int id;
        int cnt;
        int due;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mptr1 = 0;
    int   mptr2 = 0;

    function automatic int clen(int unsigned n, int maxit);
        longint unsigned v;
        int c;
        if (n == 0) return 0;
        v = n;
        c = 1;
        while (v != 1) begin
            if (c == maxit) return 32'hFFFF;
            v = v[0] ? (3 * v + 1) : (v >> 1);
            c++;
        end
        return c;
    endfunction

    function automatic int lat(int n, int c, int maxit);
        if (n == 0) return 1;
        if (c == 32'hFFFF) return maxit + 1;
        return c + 1;
    endfunction

    function automatic int rr_model(logic [3:0] m, int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    // Response monitors: every pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] oh;
        if (bus1.rsp_valid !== 4'b0000) begin
            n_cmp++;
            if (sb1.size() == 0) begin
                n_bad++;
                $display("FAIL rsp1_spurious: rsp_valid=%b count=%0d at cycle %0d, expected none", bus1.rsp_valid, bus1.rsp_count, cyc);
            end else begin
                e  = sb1.pop_front();
                oh = 4'b0001 << e.id;
                if (bus1.rsp_valid !== oh) begin
                    n_bad++;
                    $display("FAIL rsp1_owner: rsp_valid=%b want %b", bus1.rsp_valid, oh);
                end
                n_cmp++;
                if (bus1.rsp_count !== e.cnt[15:0]) begin
                    n_bad++;
                    $display("FAIL rsp1_count: got %0d want %0d", bus1.rsp_count, e.cnt);
                end
                n_cmp++;
                if (cyc != e.due) begin
                    n_bad++;
                    $display("FAIL rsp1_cycle: got cycle %0d want %0d", cyc, e.due);
                end
            end
        end
        if (bus2.rsp_valid !== 4'b0000) begin
            n_cmp++;
            if (sb2.size() == 0) begin
                n_bad++;
                $display("FAIL rsp2_spurious: rsp_valid=%b count=%0d at cycle %0d, expected none", bus2.rsp_valid, bus2.rsp_count, cyc);
            end else begin
                e  = sb2.pop_front();
                oh = 4'b0001 << e.id;
                if (bus2.rsp_valid !== oh) begin
                    n_bad++;
                    $display("FAIL rsp2_owner: rsp_valid=%b want %b", bus2.rsp_valid, oh);
                end
                n_cmp++;
                if (bus2.rsp_count !== e.cnt[15:0]) begin
                    n_bad++;
                    $display("FAIL rsp2_count: got %0d want %0d", bus2.rsp_count, e.cnt);
                end
                n_cmp++;
                if (cyc != e.due) begin
                    n_bad++;
                    $display("FAIL rsp2_cycle: got cycle %0d want %0d", cyc, e.due);
                end
            end
        end
    end

    // Waits (bounded) for the next accept on the selected bus; g==0 on timeout
    task automatic wait_grant(input int which, output logic [3:0] g, output int t);
        g = 4'b0000;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (which == 1 && bus1.req_ready !== 4'b0000) begin
                g = bus1.req_ready; t = cyc; break;
            end
            if (which == 2 && bus2.req_ready !== 4'b0000) begin
                g = bus2.req_ready; t = cyc; break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus1.req_valid = 4'b1111;
        bus1.req_n     = {32'd5, 32'd5, 32'd5, 32'd5};
        bus2.req_valid = 4'b0000;
        bus2.req_n     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus1.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", bus1.req_ready); end
        n_cmp++; if (bus1.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", bus1.rsp_valid); end
        n_cmp++; if (bus1.rsp_count !== 16'd0) begin n_bad++; $display("FAIL reset_rsp_count: got %0d want 0", bus1.rsp_count); end
        n_cmp++; if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
        n_cmp++; if (bus1.owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", bus1.owner); end
        n_cmp++;
        if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_count, bus2.busy, bus2.owner} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_dut2: got %h want 0", {bus2.req_ready, bus2.rsp_valid, bus2.rsp_count, bus2.busy, bus2.owner});
        end
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        reset = 1'b0;
        mptr1 = 0;
        mptr2 = 0;
    endtask

    task automatic test_simultaneous();
        logic [3:0] g;
        int t, e, c, l, nxt;
        int nv[4];
        nv = '{3, 6, 0, 7};
        @(posedge clk); #1;
        bus1.req_n     = {32'd7, 32'd0, 32'd6, 32'd3};
        bus1.req_valid = 4'b1011;
        nxt = 0;
        for (int k = 0; k < 3; k++) begin
            wait_grant(1, g, t);
            e = rr_model(bus1.req_valid, mptr1);
            n_cmp++;
            if (g !== (4'b0001 << e)) begin n_bad++; $display("FAIL simul_grant%0d: req_ready=%b want %b", k, g, 4'b0001 << e); end
            if (k > 0) begin
                n_cmp++;
                if (t != nxt) begin n_bad++; $display("FAIL simul_spacing%0d: grant at %0d want %0d", k, t, nxt); end
            end
            c = clen(nv[e], 65534);
            l = lat(nv[e], c, 65534);
            sb1.push_back('{e, c, t + l});
            nxt   = t + l + 1;
            mptr1 = (e + 1) % 4;
            @(posedge clk); #1;
            bus1.req_valid[e] = 1'b0;
        end
        for (int i = 0; i < 400 && sb1.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb1.size() != 0) begin n_bad++; $display("FAIL simul_drain: %0d responses missing", sb1.size()); end
    endtask

    task automatic test_single();
        logic [3:0] g;
        int t, c;
        @(posedge clk); #1;
        bus1.req_n[31:0] = 32'd1;
        bus1.req_valid   = 4'b0001;
        wait_grant(1, g, t);
        n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL single_grant: req_ready=%b want 0001", g); end
        c = clen(1, 65534);
        sb1.push_back('{0, c, t + lat(1, c, 65534)});
        mptr1 = 1;
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        for (int i = 0; i < 50 && sb1.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb1.size() != 0) begin n_bad++; $display("FAIL single_drain: response missing"); end
    endtask

    task automatic test_long_busy();
        logic [3:0] g;
        int t, c, bad_busy;
        @(posedge clk); #1;
        bus1.req_n[95:64] = 32'd27;
        bus1.req_valid    = 4'b0100;
        wait_grant(1, g, t);
        n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL long_grant: req_ready=%b want 0100", g); end
        c = clen(27, 65534);
        sb1.push_back('{2, c, t + lat(27, c, 65534)});
        mptr1 = 3;
        n_cmp++; if (bus1.busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_accept: got %b want 1", bus1.busy); end
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        bad_busy = 0;
        for (int k = 1; k <= 114; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.busy !== (k <= 113)) begin
                n_bad++;
                if (bad_busy < 4) $display("FAIL long_busy: at T+%0d busy=%b want %b", k, bus1.busy, (k <= 113));
                bad_busy++;
            end
        end
        n_cmp++; if (sb1.size() != 0) begin n_bad++; $display("FAIL long_drain: response missing"); end
    endtask

    task automatic test_zero();
        logic [3:0] g;
        int t;
        @(posedge clk); #1;
        bus1.req_n[63:32] = 32'd0;
        bus1.req_valid    = 4'b0010;
        wait_grant(1, g, t);
        n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL zero_grant: req_ready=%b want 0010", g); end
        n_cmp++; if (dut1.cgo !== 1'b0) begin n_bad++; $display("FAIL zero_cgo: got %b want 0", dut1.cgo); end
        sb1.push_back('{1, 0, t + lat(0, 0, 65534)});
        mptr1 = 2;
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        for (int i = 0; i < 20 && sb1.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb1.size() != 0) begin n_bad++; $display("FAIL zero_drain: response missing"); end
    endtask

    task automatic test_abort();
        logic [3:0] g;
        int t, c, e;
        int nv[2];
        nv = '{27, 6};
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus2.req_n[32*k +: 32] = nv[k];
            bus2.req_valid         = 4'b0001 << k;
            wait_grant(2, g, t);
            e = rr_model(bus2.req_valid, mptr2);
            n_cmp++; if (g !== (4'b0001 << e)) begin n_bad++; $display("FAIL abort_grant%0d: req_ready=%b want %b", k, g, 4'b0001 << e); end
            c = clen(nv[k], 10);
            sb2.push_back('{e, c, t + lat(nv[k], c, 10)});
            mptr2 = (e + 1) % 4;
            @(posedge clk); #1;
            bus2.req_valid = 4'b0000;
            for (int i = 0; i < 100 && sb2.size() != 0; i++) @(negedge clk);
            n_cmp++; if (sb2.size() != 0) begin n_bad++; $display("FAIL abort_drain%0d: response missing", k); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g;
        int t, t0, e, c;
        int nv[4];
        nv = '{5, 2, 0, 0};
        @(posedge clk); #1;
        bus1.req_n[95:64] = 32'd27;
        bus1.req_valid    = 4'b0100;
        wait_grant(1, g, t0);
        n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL rstmid_grant: req_ready=%b want 0100", g); end
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        while (cyc < t0 + 50) begin @(posedge clk); #1; end
        reset          = 1'b1;
        bus1.req_n     = {32'd0, 32'd0, 32'd2, 32'd5};
        bus1.req_valid = 4'b0011;
        @(negedge clk);
        n_cmp++; if (bus1.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rstmid_ready_in_reset: got %b want 0000", bus1.req_ready); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_count, bus1.busy, bus1.owner} !== 27'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %h want 0", {bus1.req_ready, bus1.rsp_valid, bus1.rsp_count, bus1.busy, bus1.owner});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mptr1 = 0;
        mptr2 = 0;
        for (int k = 0; k < 2; k++) begin
            wait_grant(1, g, t);
            e = rr_model(bus1.req_valid, mptr1);
            n_cmp++; if (g !== (4'b0001 << e)) begin n_bad++; $display("FAIL rstmid_regrant%0d: req_ready=%b want %b", k, g, 4'b0001 << e); end
            c = clen(nv[e], 65534);
            sb1.push_back('{e, c, t + lat(nv[e], c, 65534)});
            mptr1 = (e + 1) % 4;
            @(posedge clk); #1;
            bus1.req_valid[e] = 1'b0;
        end
        for (int i = 0; i < 100 && sb1.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb1.size() != 0) begin n_bad++; $display("FAIL rstmid_drain: %0d responses missing", sb1.size()); end
        // Past the point where the aborted request would have answered
        while (cyc < t0 + 125) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_long_busy();
        test_zero();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
